permutation_iterative: RTL
==========================

Name: permutation_iterative

Overview:
Iterative ASCON permutation engine, one round per clock. Each round applies three stages in order: constant addition, then couche_substitution, then couche_diffusion. Constant addition is the stage directly upstream of the substitution layer and is implemented inside this block. The block owns the 320-bit state register, the round counter and the control FSM. It sits between the mode/controller FSM and the datapath layers, and supports both p12 and p6 permutations.

Parameters:
ROUND_W, 4, width of the round counter; rounds are numbered 0..11.

Ports:
clock_i  in  1  system clock, rising edge.
reset_i  in  1  asynchronous reset, active-high.
start_i  in  1  request a permutation; sampled only in IDLE.
p12_i  in  1  sampled with start_i: 1 selects 12 rounds (0..11), 0 selects 6 rounds (6..11).
state_i  in  type_state (5x64)  input state, sampled with start_i.
state_o  out  type_state (5x64)  current contents of the state register.
round_o  out  ROUND_W  current round index.
busy_o  out  1  high in RUN.
done_o  out  1  single-cycle pulse when state_o holds the final result.
ready_o  out  1  high in IDLE; start_i is accepted this cycle.

Behaviour:
- Reset (asynchronous, whenever reset_i=1): FSM=IDLE, state register=0 (all five words), round=0, busy_o=0, done_o=0, ready_o=1. A reset during RUN aborts the permutation; no done_o is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start_i=1, next edge: state register <= state_i, round <= (p12_i ? 0 : 6), go to RUN.
  - If start_i=0, hold state and round.
- RUN, each edge:
  - state register <= diffusion(substitution(addcst(state register, round))).
  - If round=11, go to DONE with round held at 11. Otherwise round <= round+1.
- DONE: done_o=1 for exactly one cycle, state register held, next edge go to IDLE. In this cycle ready_o=0 and start_i is ignored.
- Round constant: c(r) = {4'hF - r[3:0], r[3:0]} (8 bits).
  - addcst XORs c(r) into bits [7:0] of word 2 only. Words 0, 1, 3, 4 and bits [63:8] of word 2 pass through unchanged.
  - Reference values: c(0)=0xF0, c(6)=0x96, c(11)=0x4B.
- Substitution and diffusion are instantiated combinationally (couche_substitution, couche_diffusion). The round path is purely combinational between register stages.
- Latency: start accepted at edge T. RUN covers edges T+1..T+12 for p12, or T+1..T+6 for p6. done_o is high in the cycle after the last RUN edge. p12: done_o high from T+12 to T+13. p6: done_o high from T+6 to T+7.
- start_i asserted in RUN or DONE is ignored. It is not queued.
- state_o always equals the register, so in RUN it exposes intermediate round states. The consumer qualifies the final result with done_o. The result remains on state_o in IDLE until the next accepted start.
- round_o holds 11 in IDLE after a completed permutation, until the next start.

Test Plan:
1. Reset mid-run: start p12, assert reset_i asynchronously after 5 rounds -> state_o=0, round_o=0, ready_o=1 immediately (before the next edge), and no done_o pulse.
2. First-round check: start p12 with state_i = {80400c0600000000, 8a55114d1cb6a9a2, be263d4d7aecaa0f, 4ed0ec0b98c529b7, c8cddf37bcd0284a}, then stop after 1 edge in RUN -> round_o=1, and state_o equals the golden model's diffusion(substitution(state_i with word2[7:0]^0xF0)).
3. Full p12: same state_i -> round_o steps 0..11, done_o is a single pulse exactly 12 cycles after start acceptance, and state_o matches the golden p12 output.
4. p6 path: start with p12_i=0 -> round_o sequence 6,7,...,11, done_o exactly 6 cycles after start, the constant in the first round is 0x96, and the result matches the golden p6.
5. Start ignored while busy: pulse start_i in RUN and in DONE -> no restart, round sequence undisturbed, exactly one done_o.
6. Back-to-back: assert start_i in the first IDLE cycle after DONE -> accepted, and the new permutation completes with the correct result and timing.

Source files
------------

// File: rtl/permutation_iterative.sv
// rtl/permutation_iterative.sv - iterative ASCON permutation (p12/p6), one round per clock
// State words are indexed 0..4 as x0..x4; the round path is addcst -> substitution -> diffusion.

module couche_substitution (
    input  logic [4:0][63:0] state_i,
    output logic [4:0][63:0] state_o
);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] y0, y1, y2, y3, y4;

    // Bit-sliced 5-bit S-box: input mixing, chi-like core, output mixing.
    assign x0 = state_i[0] ^ state_i[4];
    assign x1 = state_i[1];
    assign x2 = state_i[2] ^ state_i[1];
    assign x3 = state_i[3];
    assign x4 = state_i[4] ^ state_i[3];

    assign y0 = x0 ^ (~x1 & x2);
    assign y1 = x1 ^ (~x2 & x3);
    assign y2 = x2 ^ (~x3 & x4);
    assign y3 = x3 ^ (~x4 & x0);
    assign y4 = x4 ^ (~x0 & x1);

    assign state_o[0] = y0 ^ y4;
    assign state_o[1] = y1 ^ y0;
    assign state_o[2] = ~y2;
    assign state_o[3] = y3 ^ y2;
    assign state_o[4] = y4;
endmodule

module couche_diffusion (
    input  logic [4:0][63:0] state_i,
    output logic [4:0][63:0] state_o
);
    logic [63:0] x0, x1, x2, x3, x4;

    assign x0 = state_i[0];
    assign x1 = state_i[1];
    assign x2 = state_i[2];
    assign x3 = state_i[3];
    assign x4 = state_i[4];

    // Each word XORs two right-rotations of itself.
    assign state_o[0] = x0 ^ {x0[18:0], x0[63:19]} ^ {x0[27:0], x0[63:28]};
    assign state_o[1] = x1 ^ {x1[60:0], x1[63:61]} ^ {x1[38:0], x1[63:39]};
    assign state_o[2] = x2 ^ {x2[0],    x2[63:1]}  ^ {x2[5:0],  x2[63:6]};
    assign state_o[3] = x3 ^ {x3[9:0],  x3[63:10]} ^ {x3[16:0], x3[63:17]};
    assign state_o[4] = x4 ^ {x4[6:0],  x4[63:7]}  ^ {x4[40:0], x4[63:41]};
endmodule

module permutation_iterative #(
    parameter int ROUND_W = 4
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic                p12_i,
    input  logic [4:0][63:0]    state_i,
    output logic [4:0][63:0]    state_o,
    output logic [ROUND_W-1:0]  round_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                ready_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t                fsm_q;
    logic [4:0][63:0]    state_q;
    logic [4:0][63:0]    cst_d;
    logic [4:0][63:0]    sub_d;
    logic [4:0][63:0]    state_d;
    logic [ROUND_W-1:0]  round_q;
    logic                busy_q;
    logic                done_q;
    logic                ready_q;
    logic [7:0]          rc_d;

    assign rc_d = {4'hF - round_q[3:0], round_q[3:0]};

    always_comb begin
        cst_d       = state_q;
        cst_d[2]    = {state_q[2][63:8], state_q[2][7:0] ^ rc_d};
    end

    couche_substitution u_sub (
        .state_i (cst_d),
        .state_o (sub_d)
    );

    couche_diffusion u_dif (
        .state_i (sub_d),
        .state_o (state_d)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            round_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= state_i;
                        round_q <= p12_i ? ROUND_W'(0) : ROUND_W'(6);
                        fsm_q   <= RUN;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                RUN: begin
                    state_q <= state_d;
                    if (round_q == ROUND_W'(11)) begin
                        fsm_q  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        round_q <= round_q + ROUND_W'(1);
                    end
                end
                DONE: begin
                    fsm_q   <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    fsm_q   <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign state_o = state_q;
    assign round_o = round_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign ready_o = ready_q;
endmodule
